// File: rtl/uprpt_errmon_pkg.sv
// Register offsets and bus constants for the uprpt_errmon report/test block.
package uprpt_errmon_pkg;
  localparam int BUS_W     = 32;
  localparam int A_MODE    = 'h000;
  localparam int A_INSERR  = 'h001;
  localparam int A_STICKY  = 'h002;
  localparam int A_INTEN   = 'h003;
  localparam int A_INTSTAT = 'h004;
  localparam int A_SNAP    = 'h005;
  localparam int CNT_BASE  = 'h100;
  localparam int SNAP_BASE = 'h200;
endpackage

// File: rtl/uprpt_errmon_chan.sv
// One error channel: edge detect, sticky, interrupt enable, saturating counter
// and (with UPRPT_ERRMON_SNAP_EN) a counter snapshot shadow.
module uprpt_errmon_chan #(
  parameter int CNT_W = 16
)(
  input  logic             clk,
  input  logic             rst_,
  input  logic             err,
  input  logic             sticky_clr,
  input  logic             inten_we,
  input  logic             inten_d,
  input  logic             cnt_rd,
`ifdef UPRPT_ERRMON_SNAP_EN
  input  logic             snap,
  output logic [CNT_W-1:0] shadow,
`endif
  output logic             sticky,
  output logic             inten,
  output logic [CNT_W-1:0] cnt
);
  logic err_d, evt, cnt_clr;

  assign evt = err & ~err_d;
`ifdef UPRPT_ERRMON_SNAP_EN
  assign cnt_clr = cnt_rd | snap;
`else
  assign cnt_clr = cnt_rd;
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      err_d  <= 1'b0;
      sticky <= 1'b0;
      inten  <= 1'b0;
      cnt    <= '0;
    end else begin
      err_d <= err;
      // set beats W1C when both land in the same cycle
      if (evt)             sticky <= 1'b1;
      else if (sticky_clr) sticky <= 1'b0;
      if (inten_we) inten <= inten_d;
      if (cnt_clr)                  cnt <= CNT_W'(evt);
      else if (evt && cnt != '1)    cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef UPRPT_ERRMON_SNAP_EN
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)     shadow <= '0;
    else if (snap) shadow <= cnt;
  end
`endif
endmodule

// File: rtl/uprpt_errmon.sv
// CPU-bus error monitor / test-mode register page. Optional counter snapshot
// feature is enabled by defining UPRPT_ERRMON_SNAP_EN.
module uprpt_errmon
  import uprpt_errmon_pkg::*;
#(
  parameter int NCH    = 16,
  parameter int MODE_W = 8,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 12
)(
  input  logic              clk,
  input  logic              rst_,
  input  logic              upce_,
  input  logic              uprnw,
  input  logic [ADDR_W-1:0] upa,
  input  logic [BUS_W-1:0]  updi,
  output logic [BUS_W-1:0]  updo,
  output logic              upack,
  output logic              upint,
  input  logic [NCH-1:0]    error,
  output logic [MODE_W-1:0] testmode,
  output logic [NCH-1:0]    inserr
);
  logic ce_d, stb, rd_stb, wr_stb;
  logic [NCH-1:0] sticky, inten;
  logic [NCH-1:0][CNT_W-1:0] cnt;
  logic [BUS_W-1:0] rd_mux;
  logic unused_wdata;

  function automatic logic hit(input logic [ADDR_W-1:0] a, input int off);
    return a == ADDR_W'(off);
  endfunction

  assign stb          = ~upce_ & ce_d;
  assign rd_stb       = stb & uprnw;
  assign wr_stb       = stb & ~uprnw;
  assign unused_wdata = ^updi;

`ifdef UPRPT_ERRMON_SNAP_EN
  logic snap;
  logic [NCH-1:0][CNT_W-1:0] shadow;
  assign snap = wr_stb & hit(upa, A_SNAP);
`endif

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    uprpt_errmon_chan #(.CNT_W(CNT_W)) u_chan (
      .clk        (clk),
      .rst_       (rst_),
      .err        (error[n]),
      .sticky_clr (wr_stb & hit(upa, A_STICKY) & updi[n]),
      .inten_we   (wr_stb & hit(upa, A_INTEN)),
      .inten_d    (updi[n]),
      .cnt_rd     (rd_stb & hit(upa, CNT_BASE + n)),
`ifdef UPRPT_ERRMON_SNAP_EN
      .snap       (snap),
      .shadow     (shadow[n]),
`endif
      .sticky     (sticky[n]),
      .inten      (inten[n]),
      .cnt        (cnt[n])
    );
  end

  always_comb begin
    rd_mux = '0;
    if (hit(upa, A_MODE))    rd_mux = BUS_W'(testmode);
    if (hit(upa, A_INSERR))  rd_mux = BUS_W'(inserr);
    if (hit(upa, A_STICKY))  rd_mux = BUS_W'(sticky);
    if (hit(upa, A_INTEN))   rd_mux = BUS_W'(inten);
    if (hit(upa, A_INTSTAT)) rd_mux = BUS_W'(sticky & inten);
    for (int n = 0; n < NCH; n++) begin
      if (hit(upa, CNT_BASE + n))  rd_mux = BUS_W'(cnt[n]);
`ifdef UPRPT_ERRMON_SNAP_EN
      if (hit(upa, SNAP_BASE + n)) rd_mux = BUS_W'(shadow[n]);
`endif
    end
  end

  // ce_d idles high so a chip select already low at reset release still strobes
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ce_d     <= 1'b1;
      upack    <= 1'b0;
      updo     <= '0;
      upint    <= 1'b0;
      testmode <= '0;
      inserr   <= '0;
    end else begin
      ce_d  <= upce_;
      upint <= |(sticky & inten);
      if (stb) begin
        upack <= 1'b1;
        updo  <= uprnw ? rd_mux : '0;
      end else if (upce_) begin
        upack <= 1'b0;
        updo  <= '0;
      end
      if (wr_stb && hit(upa, A_MODE))   testmode <= updi[MODE_W-1:0];
      if (wr_stb && hit(upa, A_INSERR)) inserr   <= updi[NCH-1:0];
    end
  end
endmodule

// File: tb/tb_uprpt_errmon.sv
// Randomised + directed bench for uprpt_errmon against a cycle-level behavioural model.
module tb_uprpt_errmon;
  localparam int NCH = 16, MODE_W = 8, CNT_W = 4, ADDR_W = 12;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic clk = 0, rst_ = 0, upce_ = 1, uprnw = 1;
  logic [ADDR_W-1:0] upa = '0;
  logic [31:0] updi = '0, updo;
  logic upack, upint;
  logic [NCH-1:0] error = '0, inserr;
  logic [MODE_W-1:0] testmode;

  int checks = 0, errors = 0;

  uprpt_errmon #(.NCH(NCH), .MODE_W(MODE_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_(rst_), .upce_(upce_), .uprnw(uprnw), .upa(upa), .updi(updi),
    .updo(updo), .upack(upack), .upint(upint), .error(error),
    .testmode(testmode), .inserr(inserr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [MODE_W-1:0] m_mode;
  logic [NCH-1:0] m_inserr, m_sticky, m_inten, m_err_d, ev, clr;
  int m_cnt[NCH], m_shadow[NCH];
  logic m_ce_d, m_stb, m_snap, exp_ack, exp_int;
  logic [31:0] exp_do;

  function automatic logic [31:0] readval(input logic [ADDR_W-1:0] a);
    if (a == 0) return 32'(m_mode);
    if (a == 1) return 32'(m_inserr);
    if (a == 2) return 32'(m_sticky);
    if (a == 3) return 32'(m_inten);
    if (a == 4) return 32'(m_sticky & m_inten);
    if (a >= 12'h100 && a < 12'h100 + NCH) return m_cnt[a - 12'h100];
`ifdef UPRPT_ERRMON_SNAP_EN
    if (a >= 12'h200 && a < 12'h200 + NCH) return m_shadow[a - 12'h200];
`endif
    return 0;
  endfunction

  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      m_mode = '0; m_inserr = '0; m_sticky = '0; m_inten = '0; m_err_d = '0;
      for (int n = 0; n < NCH; n++) begin m_cnt[n] = 0; m_shadow[n] = 0; end
      m_ce_d = 1; exp_ack = 0; exp_int = 0; exp_do = '0;
    end else begin
      ev = error & ~m_err_d;
      m_err_d = error;
      m_stb = !upce_ && m_ce_d;
      m_ce_d = upce_;
      exp_int = |(m_sticky & m_inten);
      if (m_stb) begin exp_ack = 1; exp_do = uprnw ? readval(upa) : 0; end
      else if (upce_) begin exp_ack = 0; exp_do = 0; end
      clr = '0; m_snap = 0;
      if (m_stb && !uprnw) begin
        case (upa)
          12'h000: m_mode   = updi[MODE_W-1:0];
          12'h001: m_inserr = updi[NCH-1:0];
          12'h002: clr      = updi[NCH-1:0];
          12'h003: m_inten  = updi[NCH-1:0];
`ifdef UPRPT_ERRMON_SNAP_EN
          12'h005: m_snap   = 1;
`endif
          default: ;
        endcase
      end
      m_sticky = (m_sticky & ~clr) | ev;
      for (int n = 0; n < NCH; n++) begin
        if (m_snap) m_shadow[n] = m_cnt[n];
        if (m_snap || (m_stb && uprnw && upa == 12'(12'h100 + n))) m_cnt[n] = ev[n] ? 1 : 0;
        else if (ev[n]) m_cnt[n] = (m_cnt[n] + 1 > MAXC) ? MAXC : m_cnt[n] + 1;
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_) begin
      chk("cyc_updo", updo, exp_do);
      chk("cyc_upack", 32'(upack), 32'(exp_ack));
      chk("cyc_upint", 32'(upint), 32'(exp_int));
      chk("cyc_testmode", 32'(testmode), 32'(m_mode));
      chk("cyc_inserr", 32'(inserr), 32'(m_inserr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic acc(input bit rnw, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                     input logic [NCH-1:0] emask, input int hold, input bit chk_ack,
                     output logic [31:0] d);
    @(negedge clk);
    upce_ = 0; uprnw = rnw; upa = a; updi = wd;
    if (emask != 0) error = error | emask;
    repeat (hold + 1) @(negedge clk);
    d = updo;
    if (chk_ack) chk("ack_latency", 32'(upack), 32'd1);
    upce_ = 1;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string name);
    logic [31:0] d;
    acc(1, a, 0, '0, 1, 1, d);
    chk(name, d, exp);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] wd);
    logic [31:0] d;
    acc(0, a, wd, '0, 1, 1, d);
  endtask

  task automatic edges(input int ch, input int k);
    repeat (k) begin
      @(negedge clk); error[ch] = 1;
      @(negedge clk); error[ch] = 0;
    end
  endtask

  initial begin
    logic [31:0] d;
    repeat (3) @(negedge clk);
    rst_ = 1;
    chk("rst_updo", updo, 0);
    chk("rst_upack", 32'(upack), 0);
    chk("rst_testmode", 32'(testmode), 0);
    for (int a = 0; a < 5; a++) rd(12'(a), 0, "rst_reg");
    rd(12'h100, 0, "rst_cnt0");

    wr(12'h000, 32'hA5);
    chk("testmode_a5", 32'(testmode), 32'hA5);
    wr(12'h001, 32'h8001);
    chk("inserr_8001", 32'(inserr), 32'h8001);
    rd(12'h000, 32'hA5, "rb_mode");
    rd(12'h001, 32'h8001, "rb_inserr");

    repeat (2) begin
      @(negedge clk); error[3] = 1;
      repeat (5) @(negedge clk);
      error[3] = 0;
    end
    rd(12'h002, 32'h8, "sticky_ch3");
    rd(12'h103, 2, "cnt3_first");
    rd(12'h103, 0, "cnt3_cleared");

    wr(12'h003, 32'h8);
    wr(12'h002, 32'h8);
    repeat (2) @(negedge clk);
    chk("upint_clr", 32'(upint), 0);
    edges(3, 1);
    repeat (2) @(negedge clk);
    chk("upint_set", 32'(upint), 1);
    acc(0, 12'h002, 32'h8, 16'h8, 1, 1, d);
    error[3] = 0;
    repeat (2) @(negedge clk);
    chk("upint_setwins", 32'(upint), 1);
    rd(12'h002, 32'h8, "sticky_setwins");

    edges(0, 20);
    rd(12'h100, 15, "cnt0_sat");
    edges(0, 16);
    acc(1, 12'h100, 0, 16'h1, 1, 1, d);
    chk("cnt0_sat_coinc", d, 15);
    error[0] = 0;
    rd(12'h100, 1, "cnt0_after_coinc");

    edges(1, 7);
    wr(12'h005, 32'h1234);
`ifdef UPRPT_ERRMON_SNAP_EN
    rd(12'h201, 7, "shadow1");
    rd(12'h101, 0, "cnt1_after_snap");
    rd(12'h201, 7, "shadow1_again");
`else
    rd(12'h201, 0, "shadow1_off");
    rd(12'h101, 7, "cnt1_nosnap");
`endif
    rd(12'h3FF, 0, "unmapped");

    fork
      begin
        repeat (450) begin
          @(negedge clk);
          error = NCH'($urandom & $urandom);
        end
      end
      begin
        repeat (60) begin
          logic [ADDR_W-1:0] a;
          case ($urandom_range(0, 7))
            0, 1: a = 12'($urandom_range(0, 6));
            2, 3: a = 12'(12'h100 + $urandom_range(0, NCH + 1));
            4:    a = 12'(12'h200 + $urandom_range(0, NCH + 1));
            5:    a = 12'h005;
            6:    a = 12'h0FF;
            default: a = 12'h3FF;
          endcase
          acc($urandom_range(0, 1) == 1, a, $urandom, '0, $urandom_range(0, 2), 0, d);
          repeat ($urandom_range(1, 2)) @(negedge clk);
        end
      end
    join
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
